// File: rtl/bram_port_ctrl.sv
// rtl/bram_port_ctrl.sv - single-port BRAM request/response controller with 3-entry read FIFO
// Optional power-up zero sweep of the whole BRAM is compiled in with BRAM_CLEAR_EN.
module bram_port_ctrl #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  busy,
    output logic                  we_a,
    output logic [ADDR_WIDTH-1:0] addr_a,
    output logic [DATA_WIDTH-1:0] din_a,
    input  logic [DATA_WIDTH-1:0] dout_a
);

    typedef enum logic {CLEAR, RUN} state_t;

    localparam logic [1:0] FIFO_DEPTH = 2'd3;

    state_t                state_q;
    logic                  run;
    logic                  clearing;
    logic                  accept;
    logic                  push;
    logic                  pop;
    logic                  inflight_q;
    logic [1:0]            count_q;
    logic [1:0]            count_d;
    logic [1:0]            wr_ptr_q;
    logic [1:0]            rd_ptr_q;
    logic [DATA_WIDTH-1:0] fifo_q [3];

`ifdef BRAM_CLEAR_EN
    logic [ADDR_WIDTH-1:0] sweep_addr_q;
    logic                  busy_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= CLEAR;
            sweep_addr_q <= '0;
            busy_q       <= 1'b1;
        end else if (state_q == CLEAR) begin
            sweep_addr_q <= sweep_addr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            if (sweep_addr_q == {ADDR_WIDTH{1'b1}}) begin
                state_q <= RUN;
                busy_q  <= 1'b0;
            end
        end
    end

    // reset_n gates the sweep write so the BRAM sees nothing while reset is held
    assign clearing = (state_q == CLEAR) & reset_n;
    assign busy     = busy_q;
`else
    assign state_q  = RUN;
    assign clearing = 1'b0;
    assign busy     = 1'b0;
`endif

    assign run       = (state_q == RUN) & reset_n;
    assign req_ready = run & ((count_q + {1'b0, inflight_q}) < FIFO_DEPTH);
    assign accept    = req_valid & req_ready;
    assign push      = inflight_q;
    assign rsp_valid = (count_q != 2'd0);
    assign pop       = rsp_valid & rsp_ready;
    assign rsp_rdata = fifo_q[rd_ptr_q];

    always_comb begin
        we_a   = accept & req_we;
        addr_a = req_addr;
        din_a  = req_wdata;
        if (clearing) begin
            we_a   = 1'b1;
            addr_a = sweep_addr_q_or_zero();
            din_a  = '0;
        end
    end

    function automatic logic [ADDR_WIDTH-1:0] sweep_addr_q_or_zero();
`ifdef BRAM_CLEAR_EN
        return sweep_addr_q;
`else
        return '0;
`endif
    endfunction

    function automatic logic [1:0] next_ptr(input logic [1:0] ptr);
        return (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
    endfunction

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // dout_a holds the word read on the accepting edge, so it is captured one edge later
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inflight_q <= 1'b0;
            count_q    <= 2'd0;
            wr_ptr_q   <= 2'd0;
            rd_ptr_q   <= 2'd0;
            for (int i = 0; i < 3; i++) fifo_q[i] <= '0;
        end else begin
            inflight_q <= accept & ~req_we;
            count_q    <= count_d;
            if (push) begin
                fifo_q[wr_ptr_q] <= dout_a;
                wr_ptr_q         <= next_ptr(wr_ptr_q);
            end
            if (pop) rd_ptr_q <= next_ptr(rd_ptr_q);
        end
    end

endmodule

// File: tb/tb_bram_port_ctrl.sv
// tb/tb_bram_port_ctrl.sv - scoreboard bench for bram_port_ctrl (ADDR_WIDTH=4, DATA_WIDTH=8)
module tb_bram_port_ctrl;

    localparam int AW = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [DW-1:0] rsp_rdata;
    logic          busy;
    logic          we_a;
    logic [AW-1:0] addr_a;
    logic [DW-1:0] din_a;
    logic [DW-1:0] dout_a = '0;

    logic [DW-1:0] bram [16] = '{default: 8'hFF};
    logic [DW-1:0] model [16] = '{default: 8'hFF};
    logic [DW-1:0] exp_q [$];
    int            pop_cyc [$];
    int            tests = 0;
    int            fails = 0;
    int            cyc = 0;

    bram_port_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .busy(busy), .we_a(we_a), .addr_a(addr_a), .din_a(din_a), .dout_a(dout_a)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (we_a) bram[addr_a] <= din_a;
        dout_a <= bram[addr_a];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && rsp_valid && rsp_ready) begin
            pop_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_rsp: got 0x%0h expected no response", rsp_rdata);
            end else begin
                chk("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n = 0;
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        @(negedge clk);
        while (!req_ready && n < 60) begin n++; @(negedge clk); end
        if (!req_ready) chk("accept_timeout", 32'd0, 32'd1);
        else if (we) model[a] = d;
        else exp_q.push_back(model[a]);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin n++; @(negedge clk); end
        chk("drain", exp_q.size(), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int accepted;
        logic [AW-1:0] a;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_rdata", rsp_rdata, 8'h00);
        chk("rst_req_ready", req_ready, 1'b0);
        chk("rst_we_a", we_a, 1'b0);
`ifdef BRAM_CLEAR_EN
        chk("rst_busy", busy, 1'b1);
`else
        chk("rst_busy", busy, 1'b0);
`endif
        @(posedge clk); #1;
        reset_n = 1'b1;

`ifdef BRAM_CLEAR_EN
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("sweep_we", we_a, 1'b1);
            chk("sweep_addr", addr_a, i);
            chk("sweep_din", din_a, 8'h00);
            chk("sweep_busy", busy, 1'b1);
            chk("sweep_ready", req_ready, 1'b0);
        end
        @(negedge clk);
        chk("sweep_done_busy", busy, 1'b0);
        chk("sweep_done_ready", req_ready, 1'b1);
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
        @(posedge clk); #1;
        issue(1'b0, 4'd9, 8'h00);
        wait_drain();
`else
        @(negedge clk);
        chk("run_busy", busy, 1'b0);
        chk("run_ready", req_ready, 1'b1);
        @(posedge clk); #1;
`endif

        // write 0xA5 to 3, read 3 on the next cycle, response 2 cycles after accept
        issue(1'b1, 4'd3, 8'hA5);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd3;
        @(negedge clk);
        chk("wr_rd_ready", req_ready, 1'b1);
        exp_q.push_back(8'hA5);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("lat_cycle1_valid", rsp_valid, 1'b0);
        @(negedge clk);
        chk("lat_cycle2_valid", rsp_valid, 1'b1);
        chk("lat_cycle2_data", rsp_rdata, 8'hA5);
        @(posedge clk); #1;
        wait_drain();

        // streaming reads of 0..7
        for (int i = 0; i < 8; i++) issue(1'b1, i[AW-1:0], 8'h30 + 8'(i));
        pop_cyc.delete();
        rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            req_valid = 1'b1; req_we = 1'b0; req_addr = i[AW-1:0];
            @(negedge clk);
            chk("stream_ready", req_ready, 1'b1);
            if (req_ready) exp_q.push_back(8'h30 + 8'(i));
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        wait_drain();
        chk("stream_count", pop_cyc.size(), 32'd8);
        if (pop_cyc.size() == 8) chk("stream_span", pop_cyc[7] - pop_cyc[0], 32'd7);

        // backpressure
        issue(1'b1, 4'd8, 8'h81);
        issue(1'b1, 4'd9, 8'h82);
        issue(1'b1, 4'd10, 8'h83);
        rsp_ready = 1'b0;
        accepted = 0;
        for (int k = 0; k < 8; k++) begin
            a = 4'd8 + 4'(accepted);
            req_valid = 1'b1; req_we = 1'b0; req_addr = a;
            @(negedge clk);
            if (req_ready) begin exp_q.push_back(model[a]); accepted++; end
            @(posedge clk); #1;
        end
        chk("bp_accepted", accepted, 32'd3);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_ready_low", req_ready, 1'b0);
            chk("bp_rdata_stable", rsp_rdata, 8'h81);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_drain();
        @(negedge clk);
        chk("bp_ready_back", req_ready, 1'b1);
        @(posedge clk); #1;

        // reset with 2 responses queued and 1 in flight
        rsp_ready = 1'b0;
        issue(1'b0, 4'd0, 8'h00);
        issue(1'b0, 4'd1, 8'h00);
        issue(1'b0, 4'd2, 8'h00);
        chk("pre_rst_valid", rsp_valid, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("midrst_rsp_valid", rsp_valid, 1'b0);
        chk("midrst_req_ready", req_ready, 1'b0);
        chk("midrst_we_a", we_a, 1'b0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        rsp_ready = 1'b1;
`ifdef BRAM_CLEAR_EN
        @(negedge clk);
        chk("resweep_addr0", addr_a, 4'd0);
        begin
            int n = 0;
            while (busy && n < 100) begin n++; @(negedge clk); end
        end
        chk("resweep_done", busy, 1'b0);
`endif
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("post_rst_no_rsp", rsp_valid, 1'b0);
        end

        chk("final_queue_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
